// File: rtl/pc88_ldr_pkg.sv
// Shared types for the PC88 ROM loader bridge: FSM state, address width and FIFO entry layout.
package pc88_ldr_pkg;

    localparam int LDR_ADDR_W = 19;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } ldr_state_t;

    typedef struct packed {
        logic [LDR_ADDR_W-1:0] addr;
        logic [7:0]            data;
    } ldr_entry_t;

endpackage

// File: rtl/pc88_ldr_fifo.sv
// Small synchronous show-ahead FIFO; dout always presents the head entry.
module pc88_ldr_fifo
    import pc88_ldr_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ldr_entry_t
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 din,
    output entry_t                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];

    // Storage has no reset so it can map onto plain distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pc88_loader_bridge.sv
// Paces HPS download bytes into the PC88 SDRAM loader port through a small FIFO,
// handling ioctl_wait back-pressure and the sticky end-of-download flag.
module pc88_loader_bridge
    import pc88_ldr_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] LOADER_ADR,
    output logic [7:0]        LOADER_WDAT,
    output logic              LOADER_OE,
    output logic              LOADER_WR,
    input  logic              LOADER_ACK,
    output logic              LOADER_DONE,
    output logic              ovf
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] WAIT_LEVEL = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } entry_t;

    entry_t            fifo_din;
    entry_t            fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    ldr_state_t        state_reg;
    logic              ack_q_reg;
    logic              download_q_reg;
    logic              end_seen_reg;
    logic              wr_reg;
    logic              done_reg;
    logic              wait_reg;
    logic              ovf_reg;
    logic [ADDR_W-1:0] adr_reg;
    logic [7:0]        wdat_reg;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^ioctl_addr[24:ADDR_W];

    assign fifo_din = '{addr: ioctl_addr[ADDR_W-1:0], data: ioctl_dout};
    assign push     = ioctl_wr & ~done_reg & ~fifo_full;
    assign pop      = (state_reg == IDLE) & ~fifo_empty;

    pc88_ldr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk_sys),
        .srst  (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= IDLE;
            ack_q_reg      <= 1'b0;
            download_q_reg <= 1'b0;
            end_seen_reg   <= 1'b0;
            wr_reg         <= 1'b0;
            done_reg       <= 1'b0;
            wait_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            adr_reg        <= '0;
            wdat_reg       <= '0;
        end else begin
            ack_q_reg      <= LOADER_ACK;
            download_q_reg <= ioctl_download;
            wait_reg       <= (fifo_count >= WAIT_LEVEL);
            if (download_q_reg & ~ioctl_download) begin
                end_seen_reg <= 1'b1;
            end
            if (ioctl_wr & fifo_full) begin
                ovf_reg <= 1'b1;
            end
            // Done only once nothing is queued and no request is outstanding.
            if (end_seen_reg & fifo_empty & (state_reg == IDLE) & ~wr_reg) begin
                done_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        adr_reg   <= fifo_head.addr;
                        wdat_reg  <= fifo_head.data;
                        wr_reg    <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (LOADER_ACK & ~ack_q_reg) begin
                        wr_reg    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ioctl_wait  = wait_reg;
    assign LOADER_ADR  = adr_reg;
    assign LOADER_WDAT = wdat_reg;
    assign LOADER_WR   = wr_reg;
    assign LOADER_DONE = done_reg;
    assign ovf         = ovf_reg;
    assign LOADER_OE   = (ioctl_download | end_seen_reg) & ~done_reg;

endmodule
